banked_ram: RTL and testbench
=============================

# banked_ram

Parametrised successor to the program/data LUT RAM: a single-port, byte-enabled word memory with a valid/ready request port, fixed configurable read latency, alignment/range error reporting and a hardware zero-fill sequence after reset. It sits between the core's load/store unit and the local memory map, replacing the combinational-read RAM where timing requires registered reads.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8, min 8.
- DEPTH, 256, words; power of 2, min 4.
- RD_LAT, 1, cycles from request accept to response; legal 1..3.
- ALIAS_HI, 6, number of top address bits that select the stack alias window.
- ALIAS_LO, 6, low byte-address bits kept when aliasing.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte enables (writes only).
- req_addr  in  32  byte address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response pulse, one per accepted request.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  request was misaligned or out of range.
- init_done  out  1  zero-fill complete.

## Operation
- Accept = req_valid & req_ready. No response backpressure; the consumer must always take rsp.
- Address map: if any of req_addr[31:32-ALIAS_HI] set, effective address = req_addr[ALIAS_LO-1:0] zero-extended; else req_addr unchanged.
- Word index = effective address >> log2(DATA_W/8). Error if low log2(DATA_W/8) address bits are non-zero, or word index >= DEPTH.
- Write, no error: each byte lane i with req_be[i]=1 updated; other lanes kept. Write with be=0 legal, no change, normal response.
- Error: no array write, rsp_err=1, rsp_rdata=0.
- Read: rsp_rdata = word contents as of the accept edge (a write accepted in the previous cycle is visible).
- FSM: INIT -> RUN. INIT: counter 0..DEPTH-1 writes zero to each word, one per cycle, req_ready=0, init_done=0. On counter = DEPTH-1 -> RUN. RUN: req_ready=1, init_done=1; no exit except reset.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, FSM=INIT, counter=0, response pipeline empty.
- INIT lasts exactly DEPTH cycles after rst_n deasserts; req_ready rises on cycle DEPTH.
- Response for request accepted at edge N appears with rsp_valid=1 for one cycle after edge N+RD_LAT-1 (RD_LAT=1: the cycle right after accept). Back-to-back accepts give back-to-back responses, in order.
- Throughput: one request per cycle in RUN.
- Reset mid-operation: all in-flight responses dropped (no rsp_valid), INIT restarts, memory fully re-zeroed.
- Requests during INIT are ignored; requester must hold req_valid until ready.

## Structure
- Package banked_ram_pkg: FSM state enum (ST_INIT, ST_RUN), log2 helper function, lane-count/index-width localparam derivation.
- Sub-module ram_rsp_pipe: RD_LAT-1 stage shift register carrying {valid, err, rdata}, async active-low reset clearing valid.
- Top holds address decode, error check, array, init counter and FSM.

## Test plan
- Reset release, default params -> req_ready=0 for 256 cycles, then 1; read of 0x00 and 0x3FC -> rdata 0x00000000, err 0.
- Write 0xDEADBEEF to 0x10 be=4'b1111, then write 0x000000AA be=4'b0001, read 0x10 -> 0xDEADBEAA after 1 cycle.
- Read 0x12 (misaligned) and 0x400 (index 256) -> rsp_err=1, rdata 0; subsequent read of 0x10 unchanged.
- Write 0x11223344 to 0xFC000004, read 0x00000004 -> 0x11223344 (alias window).
- RD_LAT=3: 4 back-to-back reads to 0x0,0x4,0x8,0xC -> rsp_valid on 4 consecutive cycles starting 3 cycles after first accept, data in order.
- Assert rst_n low with 2 reads in flight -> no rsp_valid, init_done=0, previously written 0x10 reads 0 after re-init.

Source files
------------

// File: rtl/banked_ram_pkg.sv
// Shared types and parameter helpers for the banked_ram word memory.
package banked_ram_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Smallest n with 2**n >= v; returns 0 for v <= 1.
  function automatic int unsigned log2_ceil(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned lanes_of(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/ram_rsp_pipe.sv
// Extra response delay stages that stretch the read latency beyond one cycle.
module ram_rsp_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_rdata
);

  if (STAGES == 0) begin : g_bypass
    assign o_valid = i_valid;
    assign o_err   = i_err;
    assign o_rdata = i_rdata;
  end else begin : g_sr
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_err;
    logic [DATA_W-1:0] r_rdata [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= '0;
        r_err   <= '0;
        for (int unsigned s = 0; s < STAGES; s++) r_rdata[s] <= '0;
      end else begin
        r_valid[0] <= i_valid;
        r_err[0]   <= i_err;
        r_rdata[0] <= i_rdata;
        for (int unsigned s = 1; s < STAGES; s++) begin
          r_valid[s] <= r_valid[s-1];
          r_err[s]   <= r_err[s-1];
          r_rdata[s] <= r_rdata[s-1];
        end
      end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_err   = r_err[STAGES-1];
    assign o_rdata = r_rdata[STAGES-1];
  end

endmodule

// File: rtl/banked_ram.sv
// Single-port byte-enabled word RAM with fixed read latency, error reporting
// and a zero-fill sequence after every reset.
module banked_ram
  import banked_ram_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ALIAS_HI = 6,
  parameter int unsigned ALIAS_LO = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [DATA_W/8-1:0]      req_be,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     init_done
);

  localparam int unsigned LANES     = lanes_of(DATA_W);
  localparam int unsigned LANE_BITS = log2_ceil(LANES);
  localparam int unsigned IDX_W     = log2_ceil(DEPTH);

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ready, r_init_done;

  logic               w_alias, w_mis, w_oor, w_err, w_acc;
  logic [ADDR_W-1:0]  w_eff, w_word;
  logic [IDX_W-1:0]   w_idx;

  logic               w_wr_en;
  logic [IDX_W-1:0]   w_wr_idx;
  logic [LANES-1:0]   w_wr_be;
  logic [DATA_W-1:0]  w_wr_data;

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               r_s0_valid, r_s0_err;
  logic [DATA_W-1:0]  r_s0_rdata;

  // Address alias, word index and error decode.
  always_comb begin
    w_alias = |req_addr[ADDR_W-1 -: ALIAS_HI];
    w_eff   = w_alias ? {{(ADDR_W-ALIAS_LO){1'b0}}, req_addr[ALIAS_LO-1:0]} : req_addr;
    w_word  = w_eff >> LANE_BITS;
    w_mis   = |(w_eff & ADDR_W'(LANES - 1));
    w_oor   = |(w_word >> IDX_W);
    w_idx   = w_word[IDX_W-1:0];
    w_err   = w_mis | w_oor;
    w_acc   = req_valid & r_ready;
  end

  // Next state, init counter and array write port selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    w_wr_be     = '0;
    w_wr_data   = '0;
    case (r_state)
      ST_INIT: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = r_cnt;
        w_wr_be   = '1;
        w_cnt_nxt = r_cnt + IDX_W'(1);
        if (r_cnt == IDX_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (w_acc && req_we && !w_err) begin
          w_wr_en   = 1'b1;
          w_wr_idx  = w_idx;
          w_wr_be   = req_be;
          w_wr_data = req_wdata;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready     <= (w_state_nxt == ST_RUN);
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // Storage is cleared by the init sequence, so the array itself has no reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (w_wr_be[i]) r_mem[w_wr_idx][i*BYTE_W +: BYTE_W] <= w_wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // First response stage: sampled on the accept edge, before any write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0_valid <= 1'b0;
      r_s0_err   <= 1'b0;
      r_s0_rdata <= '0;
    end else begin
      r_s0_valid <= w_acc;
      r_s0_err   <= w_acc & w_err;
      r_s0_rdata <= (w_acc && !req_we && !w_err) ? r_mem[w_idx] : '0;
    end
  end

  ram_rsp_pipe #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT - 1)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_s0_valid),
    .i_err   (r_s0_err),
    .i_rdata (r_s0_rdata),
    .o_valid (rsp_valid),
    .o_err   (rsp_err),
    .o_rdata (rsp_rdata)
  );

  assign req_ready = r_ready;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_banked_ram.sv
// Scoreboard bench for banked_ram: a RD_LAT=1 default instance and a RD_LAT=3 small instance.
module tb_banked_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;

  logic        r1, rv1, re1, id1;
  logic [31:0] rd1;
  logic        r3, rv3, re3, id3;
  logic [31:0] rd3;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  banked_ram u_dut1 (
    .clk (clk), .rst_n (rst_n), .req_valid (v1), .req_ready (r1), .req_we (we),
    .req_be (be), .req_addr (addr), .req_wdata (wdata), .rsp_valid (rv1),
    .rsp_rdata (rd1), .rsp_err (re1), .init_done (id1)
  );

  banked_ram #(.DEPTH(16), .RD_LAT(3)) u_dut3 (
    .clk (clk), .rst_n (rst_n), .req_valid (v3), .req_ready (r3), .req_we (we),
    .req_be (be), .req_addr (addr), .req_wdata (wdata), .rsp_valid (rv3),
    .rsp_rdata (rd3), .rsp_err (re3), .init_done (id3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int val);
    n_chk++;
    n_err++;
    $display("FAIL %s: value %0d", name, val);
  endtask

  // Monitor: compare every presented response with the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rv1) begin
      if (q1.size() == 0) fail_now("dut1_unexpected_rsp_at_cycle", cyc);
      else begin
        e = q1.pop_front();
        chk("dut1_rdata", rd1, e.rdata);
        chk("dut1_err", {31'b0, re1}, {31'b0, e.err});
        chk("dut1_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q1.size() > 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      fail_now("dut1_missing_rsp_due_cycle", e.due);
    end
    if (rv3) begin
      if (q3.size() == 0) fail_now("dut3_unexpected_rsp_at_cycle", cyc);
      else begin
        e = q3.pop_front();
        chk("dut3_rdata", rd3, e.rdata);
        chk("dut3_err", {31'b0, re3}, {31'b0, e.err});
        chk("dut3_rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end else if (q3.size() > 0 && q3[0].due <= cyc) begin
      e = q3.pop_front();
      fail_now("dut3_missing_rsp_due_cycle", e.due);
    end
  end

  task automatic issue(input bit d3, input bit w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_e);
    exp_t e;
    @(negedge clk);
    we = w; be = b; addr = a; wdata = d;
    v1 = !d3;
    v3 = d3;
    e.rdata = exp_rd;
    e.err   = exp_e;
    e.due   = cyc + (d3 ? 3 : 1);
    if (d3) q3.push_back(e);
    else    q1.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    v1 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() > 0 || q3.size() > 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q1.size() > 0 || q3.size() > 0) fail_now("drain_timeout_pending", q1.size() + q3.size());
  endtask

  initial begin
    bit bad1, bad3;
    int n;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'b0, r1}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rv1}, 32'd0);
    chk("reset_rsp_rdata", rd1, 32'd0);
    chk("reset_rsp_err", {31'b0, re1}, 32'd0);
    chk("reset_init_done", {31'b0, id1}, 32'd0);

    rst_n = 1'b1;
    bad1 = 1'b0;
    bad3 = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i < 16 && (r3 || id3)) bad3 = 1'b1;
      if (i == 16) chk("dut3_ready_at_16", {31'b0, r3}, 32'd1);
      if (i < 256 && (r1 || id1)) bad1 = 1'b1;
    end
    chk("dut1_ready_low_during_init", {31'b0, bad1}, 32'd0);
    chk("dut3_ready_low_during_init", {31'b0, bad3}, 32'd0);
    chk("dut1_ready_at_256", {31'b0, r1}, 32'd1);
    chk("dut1_init_done_at_256", {31'b0, id1}, 32'd1);

    // RD_LAT=1 directed vectors
    issue(0, 0, 4'h0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0);
    issue(0, 0, 4'h0, 32'h0000_03FC, 32'h0, 32'h0000_0000, 0);
    issue(0, 1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0);
    issue(0, 1, 4'h1, 32'h0000_0010, 32'h0000_00AA, 32'h0, 0);
    issue(0, 0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_BEAA, 0);
    issue(0, 0, 4'h0, 32'h0000_0012, 32'h0, 32'h0, 1);
    issue(0, 0, 4'h0, 32'h0000_0400, 32'h0, 32'h0, 1);
    issue(0, 0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_BEAA, 0);
    issue(0, 1, 4'hF, 32'hFC00_0004, 32'h1122_3344, 32'h0, 0);
    issue(0, 0, 4'h0, 32'h0000_0004, 32'h0, 32'h1122_3344, 0);
    issue(0, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 0);
    issue(0, 0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_BEAA, 0);
    issue(0, 1, 4'h6, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 0);
    issue(0, 0, 4'h0, 32'h0000_0008, 32'h0, 32'h00FE_F000, 0);
    issue(0, 0, 4'h0, 32'hFFFF_FFC8, 32'h0, 32'h00FE_F000, 0);
    issue(0, 1, 4'hF, 32'h0000_0013, 32'h5555_5555, 32'h0, 1);
    issue(0, 1, 4'hF, 32'h0000_0400, 32'h5555_5555, 32'h0, 1);
    issue(0, 0, 4'h0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0);
    idle();
    drain();

    // RD_LAT=3: back-to-back writes then reads, plus an out-of-range read
    issue(1, 1, 4'hF, 32'h0000_0000, 32'hA0A0_0000, 32'h0, 0);
    issue(1, 1, 4'hF, 32'h0000_0004, 32'hA0A0_0001, 32'h0, 0);
    issue(1, 1, 4'hF, 32'h0000_0008, 32'hA0A0_0002, 32'h0, 0);
    issue(1, 1, 4'hF, 32'h0000_000C, 32'hA0A0_0003, 32'h0, 0);
    issue(1, 0, 4'h0, 32'h0000_0000, 32'h0, 32'hA0A0_0000, 0);
    issue(1, 0, 4'h0, 32'h0000_0004, 32'h0, 32'hA0A0_0001, 0);
    issue(1, 0, 4'h0, 32'h0000_0008, 32'h0, 32'hA0A0_0002, 0);
    issue(1, 0, 4'h0, 32'h0000_000C, 32'h0, 32'hA0A0_0003, 0);
    issue(1, 0, 4'h0, 32'h0000_0040, 32'h0, 32'h0, 1);
    idle();
    drain();

    // Reset with two reads in flight: responses dropped, memory re-zeroed
    issue(1, 0, 4'h0, 32'h0000_0000, 32'h0, 32'hA0A0_0000, 0);
    issue(1, 0, 4'h0, 32'h0000_0004, 32'h0, 32'hA0A0_0001, 0);
    @(negedge clk);
    rst_n = 1'b0;
    v1 = 1'b0;
    v3 = 1'b0;
    q3.delete();
    repeat (4) @(negedge clk);
    chk("midreset_init_done1", {31'b0, id1}, 32'd0);
    chk("midreset_init_done3", {31'b0, id3}, 32'd0);
    chk("midreset_ready1", {31'b0, r1}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    while (!r1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_ready_cycles", 32'(n), 32'd256);
    issue(0, 0, 4'h0, 32'h0000_0010, 32'h0, 32'h0000_0000, 0);
    issue(1, 0, 4'h0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0);
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
